// File: rtl/rv32_regfile_sb_if.sv
// Bus bundle between the decode/writeback side and the scoreboarded
// register file. The decode/writeback side uses the master modport and
// the register file uses the slave modport.
interface rv32_regfile_sb_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            rd_we;
  logic [4:0]      iss_rd_addr;
  logic            iss_valid;
  logic            flush;
  logic            ready;

  modport master (
    output rs1_addr, rs2_addr, rd_addr, rd_data, rd_we,
           iss_rd_addr, iss_valid, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, ready
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_addr, rd_data, rd_we,
           iss_rd_addr, iss_valid, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, ready
  );
endinterface

// File: rtl/rv32_regfile_sb.sv
// RV32I/RV32E register file with a pending-write scoreboard.
// The storage flops have no reset. After reset, a scrub sequence clears
// x1..x(REG_NUM-1) one register per clock, and ready then rises.
// Optional bypass forwards same-cycle writeback data to the read ports.
// With bypass, it also masks busy for the register being written back.
module rv32_regfile_sb #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 16,
  parameter int BYPASS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  rv32_regfile_sb_if.slave    bus
);

  // RV32E (16 registers) ignores address bit 4, so 4 index bits suffice.
  localparam int IW = (REG_NUM == 32) ? 5 : 4;

  typedef enum logic {
    S_SCRUB = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      cnt_q;
  logic               ready_q;
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic [XLEN-1:0]    regs_q [REG_NUM];

  logic [IW-1:0] rs1_idx;
  logic [IW-1:0] rs2_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] iss_idx;
  logic          run;
  logic          wr_en;

  // Effective register index: drops bit 4 when only 16 registers exist.
  function automatic logic [IW-1:0] eff_idx(input logic [4:0] addr);
    return addr[IW-1:0];
  endfunction

  assign rs1_idx = eff_idx(bus.rs1_addr);
  assign rs2_idx = eff_idx(bus.rs2_addr);
  assign rd_idx  = eff_idx(bus.rd_addr);
  assign iss_idx = eff_idx(bus.iss_rd_addr);

  assign run   = (state_q == S_RUN);
  assign wr_en = run && bus.rd_we && (rd_idx != '0);

  assign bus.ready = ready_q;

  // Scoreboard next state. Priority is flush, then issue-set, then writeback-clear.
  always_comb begin
    // NOTE: give every combinational output a default before any branch.
    // A path that leaves it unassigned infers a latch.
    busy_d = busy_q;
    if (run) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (bus.flush) begin
          busy_d[i] = 1'b0;
        end else if (bus.iss_valid && (iss_idx == IW'(i))) begin
          busy_d[i] = 1'b1;
        end else if (bus.rd_we && (rd_idx == IW'(i))) begin
          busy_d[i] = 1'b0;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  // Control FSM: scrub sequencing, registered ready, and the busy bits.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples its pre-edge value, whatever the order of the statements.
    if (rst) begin
      state_q <= S_SCRUB;
      cnt_q   <= IW'(1);
      ready_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      case (state_q)
        S_SCRUB: begin
          if (cnt_q == IW'(REG_NUM - 1)) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + IW'(1);
          end
        end
        S_RUN: begin
          busy_q <= busy_d;
        end
        default: begin
          state_q <= S_SCRUB;
        end
      endcase
    end
  end

  // Register storage: the scrub writes zeros, and RUN accepts writeback.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset so it maps onto plain flops or RAM.
    // The post-reset scrub produces the defined zero contents instead.
    if (state_q == S_SCRUB) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_en) begin
      regs_q[rd_idx] <= bus.rd_data;
    end
  end

  // Read port 1: zero while scrubbing and for x0, optionally forward writeback.
  always_comb begin
    bus.rs1_data = '0;
    bus.rs1_busy = 1'b0;
    if (ready_q && (rs1_idx != '0)) begin
      if ((BYPASS != 0) && bus.rd_we && (rd_idx == rs1_idx)) begin
        bus.rs1_data = bus.rd_data;
        bus.rs1_busy = 1'b0;
      end else begin
        bus.rs1_data = regs_q[rs1_idx];
        bus.rs1_busy = busy_q[rs1_idx];
      end
    end
  end

  // Read port 2: same behaviour as read port 1.
  always_comb begin
    bus.rs2_data = '0;
    bus.rs2_busy = 1'b0;
    if (ready_q && (rs2_idx != '0)) begin
      if ((BYPASS != 0) && bus.rd_we && (rd_idx == rs2_idx)) begin
        bus.rs2_data = bus.rd_data;
        bus.rs2_busy = 1'b0;
      end else begin
        bus.rs2_data = regs_q[rs2_idx];
        bus.rs2_busy = busy_q[rs2_idx];
      end
    end
  end

endmodule

// File: tb/tb_rv32_regfile_sb.sv
// Directed bench for rv32_regfile_sb. It runs two REG_NUM=16 instances side
// by side, one with BYPASS=1 (index 0) and one with BYPASS=0 (index 1).
// Both instances receive identical stimulus.
module tb_rv32_regfile_sb;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rv32_regfile_sb_if #(.XLEN(32)) if_b ();
  rv32_regfile_sb_if #(.XLEN(32)) if_n ();

  rv32_regfile_sb #(.XLEN(32), .REG_NUM(16), .BYPASS(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  rv32_regfile_sb #(.XLEN(32), .REG_NUM(16), .BYPASS(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (if_n.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] o_d1 [2];
  logic [31:0] o_d2 [2];
  logic        o_b1 [2];
  logic        o_b2 [2];
  logic        o_rdy[2];
  string       dn   [2] = '{"byp", "nobyp"};

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd, input logic [31:0] wd,
                       input logic we, input logic [4:0] iss,
                       input logic iv, input logic fl);
    if_b.rs1_addr = a1;  if_n.rs1_addr = a1;
    if_b.rs2_addr = a2;  if_n.rs2_addr = a2;
    if_b.rd_addr  = rd;  if_n.rd_addr  = rd;
    if_b.rd_data  = wd;  if_n.rd_data  = wd;
    if_b.rd_we    = we;  if_n.rd_we    = we;
    if_b.iss_rd_addr = iss; if_n.iss_rd_addr = iss;
    if_b.iss_valid   = iv;  if_n.iss_valid   = iv;
    if_b.flush       = fl;  if_n.flush       = fl;
  endtask

  task automatic sample();
    o_d1[0] = if_b.rs1_data;  o_d1[1] = if_n.rs1_data;
    o_d2[0] = if_b.rs2_data;  o_d2[1] = if_n.rs2_data;
    o_b1[0] = if_b.rs1_busy;  o_b1[1] = if_n.rs1_busy;
    o_b2[0] = if_b.rs2_busy;  o_b2[1] = if_n.rs2_busy;
    o_rdy[0] = if_b.ready;    o_rdy[1] = if_n.ready;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 1; a < 16; a++) begin
      drive(5'(a), 5'(a), 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1 sample();
      for (int d = 0; d < 2; d++) begin
        if (o_d1[d] !== 32'h0 || o_d2[d] !== 32'h0) begin
          $display("FAIL %s %s x%0d data got=%h/%h exp=0", tag, dn[d], a, o_d1[d], o_d2[d]);
          failures++;
        end
        checks++;
        if (o_b1[d] !== 1'b0 || o_b2[d] !== 1'b0) begin
          $display("FAIL %s %s x%0d busy got=%b/%b exp=0", tag, dn[d], a, o_b1[d], o_b2[d]);
          failures++;
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset();
    // rd_we and iss_valid are held high through the whole scrub; both must be ignored.
    drive(5'd3, 5'd4, 5'd3, 32'hAAAA_AAAA, 1'b1, 5'd4, 1'b1, 1'b0);
    rst = 1'b1;
    #2 sample();
    for (int d = 0; d < 2; d++) begin
      if (o_rdy[d] !== 1'b0 || o_d1[d] !== 32'h0 || o_b2[d] !== 1'b0) begin
        $display("FAIL reset_state %s got rdy=%b d1=%h b2=%b exp 0/0/0", dn[d], o_rdy[d], o_d1[d], o_b2[d]);
        failures++;
      end
      checks++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk);
      #1 sample();
      for (int d = 0; d < 2; d++) begin
        if (o_rdy[d] !== (e == 15)) begin
          $display("FAIL scrub_ready %s edge=%0d got=%b exp=%b", dn[d], e, o_rdy[d], (e == 15));
          failures++;
        end
        checks++;
        if (e < 15 && (o_d1[d] !== 32'h0 || o_b2[d] !== 1'b0)) begin
          $display("FAIL scrub_read %s edge=%0d got d1=%h b2=%b exp 0/0", dn[d], e, o_d1[d], o_b2[d]);
          failures++;
        end
        if (e < 15) checks++;
      end
    end
    read_all_zero("post_scrub");
  endtask

  task automatic test_issue_writeback();
    logic [31:0] e_wb;
    @(posedge clk);
    #1 drive(5'd5, 5'd5, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 1'b0);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      if (o_b1[d] !== 1'b0) begin
        $display("FAIL issue_pre_edge %s busy got=%b exp=0", dn[d], o_b1[d]);
        failures++;
      end
      checks++;
    end
    @(posedge clk);
    #1 drive(5'd5, 5'd5, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      if (o_b1[d] !== 1'b1 || o_d1[d] !== 32'h0) begin
        $display("FAIL issue_busy %s got b1=%b d1=%h exp 1/0", dn[d], o_b1[d], o_d1[d]);
        failures++;
      end
      checks++;
    end
    drive(5'd5, 5'd5, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd0, 1'b0, 1'b0);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      e_wb = (d == 0) ? 32'hDEAD_BEEF : 32'h0;
      if (o_d1[d] !== e_wb || o_d2[d] !== e_wb) begin
        $display("FAIL wb_same_cycle_data %s got=%h/%h exp=%h", dn[d], o_d1[d], o_d2[d], e_wb);
        failures++;
      end
      checks++;
      if (o_b1[d] !== (d == 1) || o_b2[d] !== (d == 1)) begin
        $display("FAIL wb_same_cycle_busy %s got=%b/%b exp=%b", dn[d], o_b1[d], o_b2[d], (d == 1));
        failures++;
      end
      checks++;
    end
    @(posedge clk);
    #1 drive(5'd5, 5'd5, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      if (o_d1[d] !== 32'hDEAD_BEEF || o_b1[d] !== 1'b0) begin
        $display("FAIL wb_next_cycle %s got d1=%h b1=%b exp deadbeef/0", dn[d], o_d1[d], o_b1[d]);
        failures++;
      end
      checks++;
    end
  endtask

  task automatic test_priority();
    @(posedge clk);
    #1 drive(5'd7, 5'd3, 5'd7, 32'h0000_0077, 1'b1, 5'd7, 1'b1, 1'b0);
    @(posedge clk);
    #1 drive(5'd7, 5'd3, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      if (o_d1[d] !== 32'h0000_0077 || o_b1[d] !== 1'b1) begin
        $display("FAIL iss_wb_same %s got d1=%h b1=%b exp 00000077/1", dn[d], o_d1[d], o_b1[d]);
        failures++;
      end
      checks++;
    end
    drive(5'd7, 5'd3, 5'd0, 32'h0, 1'b0, 5'd3, 1'b1, 1'b1);
    @(posedge clk);
    #1 drive(5'd7, 5'd3, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      if (o_b1[d] !== 1'b0 || o_b2[d] !== 1'b0) begin
        $display("FAIL flush_over_issue %s got b7=%b b3=%b exp 0/0", dn[d], o_b1[d], o_b2[d]);
        failures++;
      end
      checks++;
    end
  endtask

  task automatic test_alias_x0();
    @(posedge clk);
    #1 drive(5'd0, 5'd0, 5'd17, 32'h0000_1234, 1'b1, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(5'd1, 5'd17, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      if (o_d1[d] !== 32'h0000_1234 || o_d2[d] !== 32'h0000_1234) begin
        $display("FAIL alias_17 %s got x1=%h x17=%h exp 00001234", dn[d], o_d1[d], o_d2[d]);
        failures++;
      end
      checks++;
    end
    // Address 16 aliases x0 on a 16-register file.
    drive(5'd0, 5'd16, 5'd16, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 1'b0);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      if (o_d1[d] !== 32'h0 || o_d2[d] !== 32'h0 || o_b1[d] !== 1'b0) begin
        $display("FAIL x0_same_cycle %s got d1=%h d2=%h b1=%b exp 0/0/0", dn[d], o_d1[d], o_d2[d], o_b1[d]);
        failures++;
      end
      checks++;
    end
    @(posedge clk);
    #1 drive(5'd0, 5'd16, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      if (o_d1[d] !== 32'h0 || o_b1[d] !== 1'b0 || o_b2[d] !== 1'b0) begin
        $display("FAIL x0_after %s got d1=%h b1=%b b2=%b exp 0/0/0", dn[d], o_d1[d], o_b1[d], o_b2[d]);
        failures++;
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_run();
    int rise [2];
    @(posedge clk);
    #1 drive(5'd9, 5'd10, 5'd0, 32'h0, 1'b0, 5'd9, 1'b1, 1'b0);
    @(posedge clk);
    #1 drive(5'd9, 5'd10, 5'd0, 32'h0, 1'b0, 5'd10, 1'b1, 1'b0);
    @(posedge clk);
    #1 drive(5'd9, 5'd10, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      if (o_b1[d] !== 1'b1 || o_b2[d] !== 1'b1 || o_rdy[d] !== 1'b1) begin
        $display("FAIL pre_reset_busy %s got b9=%b b10=%b rdy=%b exp 1/1/1", dn[d], o_b1[d], o_b2[d], o_rdy[d]);
        failures++;
      end
      checks++;
    end
    #1 rst = 1'b1;
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      if (o_b1[d] !== 1'b0 || o_b2[d] !== 1'b0 || o_rdy[d] !== 1'b0 || o_d1[d] !== 32'h0) begin
        $display("FAIL async_reset %s got b9=%b b10=%b rdy=%b d1=%h exp 0/0/0/0", dn[d], o_b1[d], o_b2[d], o_rdy[d], o_d1[d]);
        failures++;
      end
      checks++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rise[0] = -1;
    rise[1] = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1 sample();
      for (int d = 0; d < 2; d++) begin
        if (rise[d] < 0 && o_rdy[d] === 1'b1) rise[d] = e;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (rise[d] != 15) begin
        $display("FAIL rescrub_ready_edge %s got=%0d exp=15 (-1 means never)", dn[d], rise[d]);
        failures++;
      end
      checks++;
    end
    read_all_zero("rescrub");
  endtask

  initial begin
    rst = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    test_reset();
    test_issue_writeback();
    test_priority();
    test_alias_x0();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
